// File: rtl/interlaken_pkg.sv
// Shared Interlaken RX definitions: block-lock FSM states, sync header codes, stats width.
// Latency: n/a (types and constants only). Backpressure: n/a.
// Imported by rx_block_lock and its statistics counters.
package interlaken_pkg;

    typedef enum logic [1:0] {
        INIT       = 2'd0,
        TEST       = 2'd1,
        SLIP_PULSE = 2'd2,
        SLIP_HOLD  = 2'd3
    } lock_state_t;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    localparam int STATS_W = 16;

    function automatic logic sh_is_valid(input logic [1:0] sh);
        return (sh == SH_DATA) || (sh == SH_CTRL);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
// Latency: count updates on the clock edge that samples inc.
// Backpressure: none; increments arriving at saturation are dropped.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/rx_block_lock.sv
// Interlaken RX block-lock FSM: slips the gearbox until sync headers are clean, then holds BLOCK_LOCK.
// Latency: SLIP/BLOCK_LOCK are registered, one cycle after the deciding header is sampled.
// Backpressure: none; HEADER_VALID gaps only stall counting. RX_BLOCK_LOCK_STATS_EN adds slip/lock-loss counters.
module rx_block_lock
    import interlaken_pkg::*;
#(
    parameter int SH_CNT_MAX     = 64,
    parameter int SH_INVALID_MAX = 16,
    parameter int SLIP_WAIT      = 32
) (
    input  logic       USER_CLK,
    input  logic       RESET,
    input  logic [1:0] HEADER_IN,
    input  logic       HEADER_VALID,
    output logic       SLIP,
    output logic       BLOCK_LOCK
`ifdef RX_BLOCK_LOCK_STATS_EN
    ,
    output logic [STATS_W-1:0] SLIP_COUNT,
    output logic [STATS_W-1:0] LOCK_LOSS_COUNT
`endif
);

    localparam int CW = $clog2(SH_CNT_MAX + 1);
    localparam int IW = $clog2(SH_INVALID_MAX + 1);
    localparam int HW = $clog2(SLIP_WAIT + 1);

    lock_state_t   state;
    logic [CW-1:0] sh_cnt;
    logic [IW-1:0] sh_invalid_cnt;
    logic [HW-1:0] hold_cnt;

    logic          hdr_bad;
    logic [CW-1:0] sh_cnt_nxt;
    logic [IW-1:0] sh_invalid_nxt;

    // Counts including the header being sampled this cycle.
    assign hdr_bad        = !sh_is_valid(HEADER_IN);
    assign sh_cnt_nxt     = sh_cnt + 1'b1;
    assign sh_invalid_nxt = sh_invalid_cnt + IW'(hdr_bad);

    always_ff @(posedge USER_CLK or posedge RESET) begin
        if (RESET) begin
            state          <= INIT;
            sh_cnt         <= '0;
            sh_invalid_cnt <= '0;
            hold_cnt       <= '0;
            SLIP           <= 1'b0;
            BLOCK_LOCK     <= 1'b0;
        end else begin
            SLIP <= 1'b0;
            case (state)
                INIT: begin
                    sh_cnt         <= '0;
                    sh_invalid_cnt <= '0;
                    hold_cnt       <= '0;
                    state          <= TEST;
                end
                TEST: begin
                    if (HEADER_VALID) begin
                        if (!BLOCK_LOCK && hdr_bad) begin
                            SLIP  <= 1'b1;
                            state <= SLIP_PULSE;
                        end else if (BLOCK_LOCK && (sh_invalid_nxt == IW'(SH_INVALID_MAX))) begin
                            // Lock loss outranks a window ending on the same header.
                            BLOCK_LOCK <= 1'b0;
                            SLIP       <= 1'b1;
                            state      <= SLIP_PULSE;
                        end else if (sh_cnt_nxt == CW'(SH_CNT_MAX)) begin
                            BLOCK_LOCK     <= 1'b1;
                            sh_cnt         <= '0;
                            sh_invalid_cnt <= '0;
                        end else begin
                            sh_cnt         <= sh_cnt_nxt;
                            sh_invalid_cnt <= sh_invalid_nxt;
                        end
                    end
                end
                SLIP_PULSE: begin
                    hold_cnt <= HW'(SLIP_WAIT);
                    state    <= SLIP_HOLD;
                end
                SLIP_HOLD: begin
                    hold_cnt <= hold_cnt - 1'b1;
                    if (hold_cnt == HW'(1)) begin
                        sh_cnt         <= '0;
                        sh_invalid_cnt <= '0;
                        state          <= TEST;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

`ifdef RX_BLOCK_LOCK_STATS_EN
    logic block_lock_q;

    always_ff @(posedge USER_CLK or posedge RESET) begin
        if (RESET) begin
            block_lock_q <= 1'b0;
        end else begin
            block_lock_q <= BLOCK_LOCK;
        end
    end

    sat_counter #(.W(STATS_W)) u_slip_cnt (
        .clk   (USER_CLK),
        .rst   (RESET),
        .inc   (SLIP),
        .count (SLIP_COUNT)
    );

    sat_counter #(.W(STATS_W)) u_lock_loss_cnt (
        .clk   (USER_CLK),
        .rst   (RESET),
        .inc   (block_lock_q && !BLOCK_LOCK),
        .count (LOCK_LOSS_COUNT)
    );
`endif

endmodule

// File: tb/tb_rx_block_lock.sv
// Directed bench for rx_block_lock with default parameters (64/16/32).
// Latency: n/a. Backpressure: n/a. Stats checks compile in with RX_BLOCK_LOCK_STATS_EN.
module tb_rx_block_lock;

    localparam int W = 32;

    logic       USER_CLK;
    logic       RESET;
    logic [1:0] HEADER_IN;
    logic       HEADER_VALID;
    logic       SLIP;
    logic       BLOCK_LOCK;
`ifdef RX_BLOCK_LOCK_STATS_EN
    logic [15:0] SLIP_COUNT;
    logic [15:0] LOCK_LOSS_COUNT;
`endif

    rx_block_lock dut (
        .USER_CLK        (USER_CLK),
        .RESET           (RESET),
        .HEADER_IN       (HEADER_IN),
        .HEADER_VALID    (HEADER_VALID),
        .SLIP            (SLIP),
        .BLOCK_LOCK      (BLOCK_LOCK)
`ifdef RX_BLOCK_LOCK_STATS_EN
        ,
        .SLIP_COUNT      (SLIP_COUNT),
        .LOCK_LOSS_COUNT (LOCK_LOSS_COUNT)
`endif
    );

    initial USER_CLK = 1'b0;
    always #5 USER_CLK = ~USER_CLK;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Independent SLIP monitor: every high cycle is logged with its cycle index.
    int cyc = 0;
    int slip_pulses = 0;
    int slip_cyc[$];
    always @(posedge USER_CLK) cyc <= cyc + 1;
    always @(negedge USER_CLK) begin
        if (SLIP === 1'b1) begin
            slip_pulses++;
            slip_cyc.push_back(cyc);
        end
    end

    // Present one header for one rising edge; returns just after that edge.
    task automatic step(input logic v, input logic [1:0] h);
        @(negedge USER_CLK);
        HEADER_VALID = v;
        HEADER_IN    = h;
        @(posedge USER_CLK);
        #1;
    endtask

    task automatic hold_out();
        step(1'b0, 2'b00);
        repeat (W) step(1'b1, 2'b11);
    endtask

    int base;
    int sidx;

    initial begin
        RESET        = 1'b1;
        HEADER_VALID = 1'b0;
        HEADER_IN    = 2'b00;
        #1;
        chk("reset_slip", SLIP, 0);
        chk("reset_lock", BLOCK_LOCK, 0);
        #22;
        RESET = 1'b0;
        step(1'b0, 2'b00);

        // Clean lock with a gap of invalid-but-not-valid headers mid-window.
        base = slip_pulses;
        for (int i = 0; i < 64; i++) begin
            if (i == 30) repeat (3) step(1'b0, 2'b11);
            step(1'b1, (i % 2) ? 2'b10 : 2'b01);
            if (i == 62) chk("clean_lock_at63", BLOCK_LOCK, 0);
        end
        chk("clean_lock_at64", BLOCK_LOCK, 1);
        chk("clean_no_slip", slip_pulses - base, 0);

        // Three windows of 15 errors each stay locked.
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 64; i++)
                step(1'b1, ((i % 4 == 0) && (i < 60)) ? 2'b00 : 2'b01);
            chk("tol_lock", BLOCK_LOCK, 1);
            chk("tol_no_slip", slip_pulses - base, 0);
        end

        // 16 errors in one window: lock loss on the 16th.
        for (int i = 0; i < 32; i++) begin
            step(1'b1, (i % 2) ? 2'b11 : 2'b01);
            if (i == 29) chk("loss_before16", BLOCK_LOCK, 1);
        end
        chk("loss_slip_hi", SLIP, 1);
        chk("loss_lock_lo", BLOCK_LOCK, 0);
        step(1'b0, 2'b00);
        chk("loss_slip_lo", SLIP, 0);
`ifdef RX_BLOCK_LOCK_STATS_EN
        chk("stat_slip_cnt", SLIP_COUNT, 1);
        chk("stat_loss_cnt", LOCK_LOSS_COUNT, 1);
`endif
        base = slip_pulses;
        repeat (W) step(1'b1, 2'b11);
        chk("hold_ignores_hdr", slip_pulses - base, 0);

        // Misaligned: three slips at minimum spacing, then lock.
        sidx = slip_cyc.size();
        for (int s = 0; s < 3; s++) begin
            step(1'b1, 2'b11);
            chk("mis_slip_hi", SLIP, 1);
            hold_out();
        end
        chk("mis_slip_count", slip_pulses - base, 3);
        if (slip_cyc.size() >= sidx + 3) begin
            chk("mis_gap0", slip_cyc[sidx+1] - slip_cyc[sidx], W + 2);
            chk("mis_gap1", slip_cyc[sidx+2] - slip_cyc[sidx+1], W + 2);
        end else begin
            chk("mis_gap_logged", slip_cyc.size() - sidx, 3);
        end
        // Header after the hold is counted; replace the junk the hold drove.
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 2'b10);
            if (i == 62) chk("mis_lock_at63", BLOCK_LOCK, 0);
        end
        chk("mis_lock_at64", BLOCK_LOCK, 1);

        // Window's last header is also the 16th error: lock loss wins.
        base = slip_pulses;
        for (int i = 0; i < 64; i++) begin
            step(1'b1, ((i < 15) || (i == 63)) ? 2'b00 : 2'b01);
            if (i == 62) chk("prio_lock_at63", BLOCK_LOCK, 1);
        end
        chk("prio_lock_lo", BLOCK_LOCK, 0);
        chk("prio_slip_hi", SLIP, 1);

        // Async reset in the middle of the hold period.
        repeat (6) step(1'b0, 2'b00);
        #2;
        RESET = 1'b1;
        #1;
        chk("rst_hold_slip", SLIP, 0);
        chk("rst_hold_lock", BLOCK_LOCK, 0);
`ifdef RX_BLOCK_LOCK_STATS_EN
        chk("rst_stat_slip", SLIP_COUNT, 0);
`endif
        #9;
        RESET = 1'b0;
        step(1'b0, 2'b00);
        base = slip_pulses;
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 2'b01);
            if (i == 62) chk("relock_at63", BLOCK_LOCK, 0);
        end
        chk("relock_at64", BLOCK_LOCK, 1);
        chk("relock_no_slip", slip_pulses - base, 0);

        // Reset while locked clears BLOCK_LOCK without waiting for an edge.
        #2;
        RESET = 1'b1;
        #1;
        chk("rst_locked_lock", BLOCK_LOCK, 0);
        #7;
        RESET = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rx_block_lock.md
# rx_block_lock

Interlaken receive block-alignment controller. Sits beside the RX gearbox and inspects the 2-bit sync header of every 67-bit block the gearbox emits. It issues single-cycle SLIP requests to the gearbox until the headers are consistently valid, then declares BLOCK_LOCK. While locked it keeps monitoring and drops lock on an excessive error rate, following the Interlaken and 802.3 block-lock state machine.

## Interface
Parameters:
- SH_CNT_MAX, 64: headers per lock-test window.
- SH_INVALID_MAX, 16: invalid headers within one window that cause lock loss. Legal range is 1..SH_CNT_MAX.
- SLIP_WAIT, 32: cycles to ignore headers after a slip while the gearbox realigns. Must be ≥1.

Ports:
- USER_CLK, in, 1: sole clock, rising edge.
- RESET, in, 1: asynchronous, active-high reset.
- HEADER_IN, in, 2: sync header of the current block.
- HEADER_VALID, in, 1: HEADER_IN is meaningful this cycle.
- SLIP, out, 1: one-cycle request to the gearbox to shift alignment by one bit.
- BLOCK_LOCK, out, 1: block alignment achieved.

## Operation
- A header is valid when it equals 2'b01 or 2'b10. A header of 2'b00 or 2'b11 is invalid.
- FSM states: INIT, TEST, SLIP_PULSE, SLIP_HOLD.
- INIT: clear sh_cnt, sh_invalid_cnt and the hold counter. Go to TEST on the next cycle.
- TEST: on each cycle with HEADER_VALID=1, increment sh_cnt. If the header is invalid, also increment sh_invalid_cnt. Evaluate the following in priority order, using counts that include the current header:
  1. Not locked and header invalid: go to SLIP_PULSE.
  2. Locked and sh_invalid_cnt reaches SH_INVALID_MAX: clear BLOCK_LOCK and go to SLIP_PULSE.
  3. sh_cnt reaches SH_CNT_MAX: set BLOCK_LOCK and clear both counters. A locked window that ends with fewer than SH_INVALID_MAX errors stays locked.
- SLIP_PULSE: assert SLIP for exactly one cycle, load the hold counter with SLIP_WAIT, then go to SLIP_HOLD.
- SLIP_HOLD: decrement the hold counter and ignore HEADER_VALID. When the counter reaches 0, clear both header counters and go to TEST.
- Counter widths: $clog2(SH_CNT_MAX+1), $clog2(SH_INVALID_MAX+1) and $clog2(SLIP_WAIT+1). Counters never wrap because they are cleared at window end, on slip, or in INIT.
- Simultaneous events:
  - The final header of a window also being the SH_INVALID_MAX-th error: lock loss wins and no window reset occurs.
  - Unlocked with the final header of the window invalid: slip, not lock.

## Timing
- Reset values: SLIP=0, BLOCK_LOCK=0, state=INIT, all counters 0. Outputs clear immediately on RESET assertion, including mid-pulse and mid-hold.
- All outputs are registered.
- SLIP rises 1 cycle after the offending header is sampled and falls 1 cycle later.
- BLOCK_LOCK rises 1 cycle after the SH_CNT_MAX-th valid header is sampled while unlocked.
- BLOCK_LOCK falls in the same cycle that SLIP rises.
- After SLIP deasserts, SLIP_WAIT cycles pass before the first header is counted again.
- Minimum spacing between SLIP pulses is SLIP_WAIT+2 cycles.
- HEADER_VALID may be low in any cycle. Gaps only stall counting.

## Configuration
- RX_BLOCK_LOCK_STATS_EN defined: adds output ports SLIP_COUNT[15:0] and LOCK_LOSS_COUNT[15:0].
  - Both are saturating counters, reset to 0.
  - SLIP_COUNT increments on every SLIP pulse.
  - LOCK_LOSS_COUNT increments on every 1→0 transition of BLOCK_LOCK.
  - Both hold at 16'hFFFF once saturated.
- RX_BLOCK_LOCK_STATS_EN undefined: these ports and their counters do not exist. Core behaviour is identical.

## Structure
- Shared package interlaken_pkg holds:
  - the FSM state encoding;
  - the sync header constants SH_DATA=2'b01 and SH_CTRL=2'b10;
  - the statistics counter width (16).
- Sub-module sat_counter: a parameterised-width saturating incrementer with async reset. It is used for both statistics counters and is only instantiated under the macro.
- All other logic is a single FSM with three counters.

## Test plan
- Clean lock: 64 headers of 2'b01 after reset. BLOCK_LOCK=1 one cycle after the 64th header, SLIP never asserted.
- Misaligned start: headers 2'b11 for 3 realignments, then valid. Expect exactly 3 SLIP pulses, each 34 cycles apart (SLIP_WAIT=32), then lock after 64 valid headers.
- Tolerated errors: while locked, 15 invalid headers spread over a 64-header window, repeated for 3 windows. BLOCK_LOCK stays 1 and no SLIP.
- Lock loss: while locked, 16 invalid headers within one window. BLOCK_LOCK falls and SLIP pulses one cycle after the 16th error. With the macro defined, LOCK_LOSS_COUNT=1 and SLIP_COUNT=1.
- Priority: locked, and the 64th header of the window is the 16th error. Lock is lost rather than the window resetting.
- Async reset mid-SLIP_HOLD: assert RESET for 1 cycle. SLIP=0 and BLOCK_LOCK=0 immediately. After release, 64 valid headers give lock with no further slip.
